// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: LEGv8 multicycle control FSM and sole aluOp source.
// Optional retired-instruction counter via CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        mem_ready,
  output logic [3:0]  aluOp,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_ADD,
    C_SUB,
    C_AND,
    C_ORR,
    C_LDUR,
    C_STUR,
    C_B,
    C_CBZ,
    C_CBNZ,
    C_ILL
  } cls_t;

  state_t state;
  state_t state_nx;
  cls_t   cls;
  cls_t   cls_dec;
  logic   accept;
  logic   retire;
  logic   is_r;
  logic   is_m;
  logic   is_br;
  logic [3:0] cls_alu;
  logic   cls_src;
  logic [10:0] op11;

  assign op11   = inst[31:21];
  assign accept = inst_valid & (state == S_FETCH);

  // Low operand bits never influence control.
  logic unused_inst;
  assign unused_inst = ^inst[20:0];

  // Opcode classifier; patterns are mutually exclusive.
  always_comb begin
    cls_dec = C_ILL;
    unique case (1'b1)
      (op11 == 11'b10001011000):      cls_dec = C_ADD;
      (op11 == 11'b11001011000):      cls_dec = C_SUB;
      (op11 == 11'b10001010000):      cls_dec = C_AND;
      (op11 == 11'b10101010000):      cls_dec = C_ORR;
      (op11 == 11'b11111000010):      cls_dec = C_LDUR;
      (op11 == 11'b11111000000):      cls_dec = C_STUR;
      (inst[31:26] == 6'b000101):     cls_dec = C_B;
      (inst[31:24] == 8'b10110100):   cls_dec = C_CBZ;
      (inst[31:24] == 8'b10110101):   cls_dec = C_CBNZ;
      default:                        cls_dec = C_ILL;
    endcase
  end

  // Per-class ALU code, operand select and group flags.
  always_comb begin
    cls_alu = 4'b0000;
    cls_src = 1'b0;
    is_r    = 1'b0;
    is_m    = 1'b0;
    is_br   = 1'b0;
    unique case (cls)
      C_ADD:  begin cls_alu = 4'b0010; is_r = 1'b1; end
      C_SUB:  begin cls_alu = 4'b0110; is_r = 1'b1; end
      C_AND:  begin cls_alu = 4'b0000; is_r = 1'b1; end
      C_ORR:  begin cls_alu = 4'b0001; is_r = 1'b1; end
      C_LDUR: begin cls_alu = 4'b0010; cls_src = 1'b1; is_m = 1'b1; end
      C_STUR: begin cls_alu = 4'b0010; cls_src = 1'b1; is_m = 1'b1; end
      C_B:    begin cls_alu = 4'b1000; is_br = 1'b1; end
      C_CBZ:  begin cls_alu = 4'b0111; is_br = 1'b1; end
      C_CBNZ: begin cls_alu = 4'b1001; is_br = 1'b1; end
      default: cls_alu = 4'b0000;
    endcase
  end

  // State and class registers; class captured at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cls   <= C_ILL;
    end else begin
      state <= state_nx;
      if (accept) cls <= cls_dec;
    end
  end

  // Next state and strobes.
  always_comb begin
    state_nx   = state;
    inst_ready = 1'b0;
    aluOp      = 4'b0000;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    unique case (state)
      S_FETCH: begin
        inst_ready = 1'b1;
        if (accept) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          illegal  = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        aluOp   = cls_alu;
        alu_src = cls_src;
        unique case (1'b1)
          is_r: state_nx = S_WB;
          is_m: state_nx = S_MEM;
          is_br: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        aluOp     = 4'b0010;
        alu_src   = 1'b1;
        mem_read  = (cls == C_LDUR);
        mem_write = (cls == C_STUR);
        if (mem_ready) begin
          if (cls == C_LDUR) begin
            state_nx = S_WB;
          end else begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LDUR);
        retire     = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{retire, (CNT_W > 0)};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Stimulus queues per-cycle expected outputs; a monitor compares.
module tb_multicycle_ctrl;

  localparam int CW = `ifdef CTRL_PERF_CNT_EN 4 `else 32 `endif;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        mem_ready;
  logic [3:0]  aluOp;
  logic        alu_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [CW-1:0] retired;
`endif

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .inst(inst),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .mem_ready(mem_ready),
    .aluOp(aluOp),
    .alu_src(alu_src),
    .reg_write(reg_write),
    .mem_to_reg(mem_to_reg),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
    ,
    .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] v;
    bit          rc;
    int unsigned r;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit rc_next = 1'b0;
  int unsigned r_next = 0;

  // {inst_ready, aluOp, alu_src, reg_write, mem_to_reg,
  //  mem_read, mem_write, ir_write, pc_write, pc_src, illegal}
  function automatic logic [13:0] mk(
    input logic rdy, input logic [3:0] op, input logic src,
    input logic rw, input logic m2r, input logic mr,
    input logic mw, input logic irw, input logic pw,
    input logic ps, input logic ill);
    mk = {rdy, op, src, rw, m2r, mr, mw, irw, pw, ps, ill};
  endfunction

  logic [13:0] got;
  assign got = {inst_ready, aluOp, alu_src, reg_write,
                mem_to_reg, mem_read, mem_write, ir_write,
                pc_write, pc_src, illegal};

  // Monitor: one expected entry per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL outputs t=%0t got=%b exp=%b",
                 $time, got, e.v);
      end
`ifdef CTRL_PERF_CNT_EN
      if (e.rc) begin
        checks++;
        if (32'(retired) !== e.r) begin
          failures++;
          $display("FAIL retired t=%0t got=%0d exp=%0d",
                   $time, retired, e.r);
        end
      end
`endif
    end
  end

  task automatic step(input logic [13:0] v,
                      input logic vld, input logic mrdy);
    exp_t e;
    inst_valid = vld;
    mem_ready  = mrdy;
    e.v  = v;
    e.rc = rc_next;
    e.r  = r_next;
    rc_next = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input int unsigned r);
    rc_next = 1'b1;
    r_next  = r;
  endtask

  logic [13:0] v_idle, v_acc, v_zero;

  task automatic acc(input logic [31:0] w);
    inst = w;
    step(v_acc, 1'b1, 1'b1);
  endtask

  task automatic rtype(input logic [31:0] w, input logic [3:0] op);
    acc(w);
    step(v_zero, 1'b1, 1'b0);
    step(mk(0, op, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    step(mk(0, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
  endtask

  task automatic ldur(input logic [31:0] w, input int waits);
    logic [13:0] vm;
    vm = mk(0, 4'b0010, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    acc(w);
    step(v_zero, 1'b1, 1'b0);
    step(mk(0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    for (int i = 0; i < waits; i++) step(vm, 1'b1, 1'b0);
    step(vm, 1'b1, 1'b1);
    step(mk(0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
  endtask

  task automatic stur(input logic [31:0] w, input int waits);
    logic [13:0] vm;
    vm = mk(0, 4'b0010, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    acc(w);
    step(v_zero, 1'b1, 1'b1);
    step(mk(0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    for (int i = 0; i < waits; i++) step(vm, 1'b1, 1'b0);
    step(vm, 1'b1, 1'b1);
  endtask

  task automatic branch(input logic [31:0] w, input logic [3:0] op);
    acc(w);
    step(v_zero, 1'b1, 1'b1);
    step(mk(0, op, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t queue=%0d", $time, q.size());
    $fatal(1, "timeout");
  end

  initial begin
    v_idle = mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_acc  = mk(1, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    v_zero = mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    inst = 32'h0;
    inst_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_ret(0);
    step(v_idle, 1'b0, 1'b1);
    reset = 1'b0;
    step(v_idle, 1'b0, 1'b1);

    rtype(32'h8B020020, 4'b0010);
    step(v_idle, 1'b0, 1'b1);
    rtype(32'hCB020020, 4'b0110);
    rtype(32'h8A020020, 4'b0000);
    rtype(32'hAA020020, 4'b0001);
    step(v_idle, 1'b0, 1'b1);
    ldur(32'hF8400020, 2);
    stur(32'hF8000020, 1);
    stur(32'hF8000020, 0);
    ldur(32'hF8400020, 0);
    branch(32'hB5000040, 4'b1001);
    branch(32'h14000003, 4'b1000);
    branch(32'hB4000040, 4'b0111);

    acc(32'hFFFFFFFF);
    chk_ret(11);
    step(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b1);
    chk_ret(11);
    step(v_idle, 1'b0, 1'b1);

    acc(32'hF8400020);
    step(v_zero, 1'b1, 1'b1);
    step(mk(0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    step(mk(0, 4'b0010, 1, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    reset = 1'b1;
    step(mk(0, 4'b0010, 1, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    reset = 1'b0;
    chk_ret(0);
    step(v_idle, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) branch(32'h14000003, 4'b1000);
    chk_ret(17 % 16);
    step(v_idle, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
